// File: rtl/sd_seq_if.sv
// sd_seq_if: command/data handshake between the SD sequencer and transceiver.
// master = sequencer side, slave = transceiver side.
interface sd_seq_if;
   logic [5:0]  ocmd_index;
   logic [31:0] ocmd_arg;
   logic        ostart_cmd;
   logic        icmd_done;
   logic [31:0] iresp;
   logic        ostart_d;
   logic        odata_wr;
   logic        idata_done;
   logic        idata_crc_fail;

   modport master (
      output ocmd_index, ocmd_arg, ostart_cmd,
      output ostart_d, odata_wr,
      input  icmd_done, iresp,
      input  idata_done, idata_crc_fail
   );

   modport slave (
      input  ocmd_index, ocmd_arg, ostart_cmd,
      input  ostart_d, odata_wr,
      output icmd_done, iresp,
      output idata_done, idata_crc_fail
   );
endinterface

// File: rtl/sd_seq.sv
// sd_seq: SD-bus command sequencer (init, bus switch, block read/write loop).
// Ports: iclk/irst (async low), istart/iread/iwrite from cipher control,
//   bus = transceiver handshake, status outputs osel_clk/owide/oaddr_sd,
//   oblock_ready/obusy, result pulses osuccess/ofail, ofail_code.
module sd_seq #(
   parameter int BUS_WIDTH      = 4,
   parameter int NUM_BLOCKS     = 8388608,
   parameter int ADDR_W         = 23,
   parameter int ACMD41_TRIES   = 255,
   parameter int CRC_RETRIES    = 3,
   parameter int TIMEOUT_CYCLES = 4194304
) (
   input  logic              iclk,
   input  logic              irst,
   input  logic              istart,
   input  logic              iread,
   input  logic              iwrite,
   sd_seq_if.master          bus,
   output logic              osel_clk,
   output logic              owide,
   output logic [ADDR_W-1:0] oaddr_sd,
   output logic              oblock_ready,
   output logic              obusy,
   output logic              osuccess,
   output logic              ofail,
   output logic [2:0]        ofail_code
);

   localparam int A41_W = (ACMD41_TRIES < 2) ? 1 : $clog2(ACMD41_TRIES + 1);
   localparam int CRC_W = (CRC_RETRIES < 2) ? 1 : $clog2(CRC_RETRIES + 1);
   localparam int WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_C55, S_A41, S_C2, S_C3, S_C7, S_C55B, S_A6,
      S_WAIT, S_C17, S_READ, S_HOLD, S_C24, S_WRITE, S_C15
   } state_e;

   state_e             state_q, state_d;
   logic [15:0]        rca_q, rca_d;
   logic [A41_W-1:0]   a41_q, a41_d, a41_inc;
   logic [CRC_W-1:0]   crc_q, crc_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               sel_q, sel_d;
   logic               wide_q, wide_d;
   logic [2:0]         code_q, code_d;
   logic               cmd_q, cmd_d;
   logic               dst_q, dst_d;
   logic               succ_q, succ_d;
   logic               fail_q, fail_d;

   logic               wd_live;
   logic               do_fail;
   logic [2:0]         fcode;
   logic               enter;
   logic [ADDR_W+8:0]  blk_full;
   logic [31:0]        blk_arg;
   logic [31:0]        rca_arg;

   assign a41_inc  = a41_q + A41_W'(1);
   assign blk_full = {addr_q, 9'h0};
   assign blk_arg  = 32'(blk_full);
   assign rca_arg  = {rca_q, 16'h0};

   // Host-paced states are exempt from the watchdog.
   assign wd_live = (state_q != S_IDLE) &&
                    (state_q != S_WAIT) &&
                    (state_q != S_HOLD);

   // State register
   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         state_q <= S_IDLE;
         rca_q   <= '0;
         a41_q   <= '0;
         crc_q   <= '0;
         wd_q    <= '0;
         addr_q  <= '0;
         sel_q   <= 1'b0;
         wide_q  <= 1'b0;
         code_q  <= 3'd0;
         cmd_q   <= 1'b0;
         dst_q   <= 1'b0;
         succ_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rca_q   <= rca_d;
         a41_q   <= a41_d;
         crc_q   <= crc_d;
         wd_q    <= wd_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wide_q  <= wide_d;
         code_q  <= code_d;
         cmd_q   <= cmd_d;
         dst_q   <= dst_d;
         succ_q  <= succ_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      rca_d   = rca_q;
      a41_d   = a41_q;
      crc_d   = crc_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wide_d  = wide_q;
      code_d  = code_q;
      succ_d  = 1'b0;
      fail_d  = 1'b0;
      do_fail = 1'b0;
      fcode   = 3'd0;

      if (wd_live && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
         do_fail = 1'b1;
         fcode   = 3'd5;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (istart) begin
                  code_d  = 3'd0;
                  sel_d   = 1'b0;
                  wide_d  = 1'b0;
                  addr_d  = '0;
                  rca_d   = '0;
                  a41_d   = '0;
                  crc_d   = '0;
                  state_d = S_C55;
               end
            end
            S_C55, S_C55B: begin
               if (bus.icmd_done) begin
                  if (!bus.iresp[5]) begin
                     do_fail = 1'b1;
                     fcode   = 3'd1;
                  end else if (sel_q) begin
                     state_d = S_A6;
                  end else begin
                     state_d = S_A41;
                  end
               end
            end
            S_A41: begin
               if (bus.icmd_done) begin
                  if (bus.iresp[31]) begin
                     state_d = S_C2;
                  end else if (a41_inc == A41_W'(ACMD41_TRIES)) begin
                     do_fail = 1'b1;
                     fcode   = 3'd2;
                  end else begin
                     a41_d   = a41_inc;
                     state_d = S_C55;
                  end
               end
            end
            S_C2: begin
               if (bus.icmd_done) state_d = S_C3;
            end
            S_C3: begin
               if (bus.icmd_done) begin
                  rca_d   = bus.iresp[31:16];
                  state_d = S_C7;
               end
            end
            S_C7: begin
               if (bus.icmd_done) begin
                  sel_d   = 1'b1;
                  state_d = (BUS_WIDTH == 4) ? S_C55B : S_WAIT;
               end
            end
            S_A6: begin
               if (bus.icmd_done) begin
                  if (bus.iresp[12:9] == 4'd4) begin
                     wide_d  = 1'b1;
                     state_d = S_WAIT;
                  end else begin
                     do_fail = 1'b1;
                     fcode   = 3'd3;
                  end
               end
            end
            S_WAIT: begin
               if (iread) state_d = S_C17;
            end
            S_C17: begin
               if (bus.icmd_done) begin
                  state_d = bus.iresp[31] ? S_C15 : S_READ;
               end
            end
            S_READ: begin
               if (bus.idata_done) begin
                  if (!bus.idata_crc_fail) begin
                     crc_d   = '0;
                     state_d = S_HOLD;
                  end else if (crc_q < CRC_W'(CRC_RETRIES)) begin
                     crc_d   = crc_q + CRC_W'(1);
                     state_d = S_C17;
                  end else begin
                     do_fail = 1'b1;
                     fcode   = 3'd4;
                  end
               end
            end
            S_HOLD: begin
               if (iwrite) state_d = S_C24;
            end
            S_C24: begin
               if (bus.icmd_done) state_d = S_WRITE;
            end
            S_WRITE: begin
               if (bus.idata_done) begin
                  if (addr_q == ADDR_W'(NUM_BLOCKS - 1)) begin
                     state_d = S_C15;
                  end else begin
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = S_WAIT;
                  end
               end
            end
            S_C15: begin
               if (bus.icmd_done) begin
                  succ_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (do_fail) begin
         fail_d  = 1'b1;
         code_d  = fcode;
         sel_d   = 1'b0;
         wide_d  = 1'b0;
         addr_d  = '0;
         a41_d   = '0;
         crc_d   = '0;
         state_d = S_IDLE;
      end

      enter = (state_d != state_q);

      // Watchdog restarts on every state change.
      if (enter || !wd_live) wd_d = '0;
      else                   wd_d = wd_q + WD_W'(1);

      // Launch pulses coincide with the first cycle of the new state.
      cmd_d = enter &&
              (state_d != S_IDLE) && (state_d != S_WAIT) &&
              (state_d != S_READ) && (state_d != S_HOLD) &&
              (state_d != S_WRITE);
      dst_d = enter &&
              ((state_d == S_READ) || (state_d == S_WRITE));
   end

   // Outputs
   always_comb begin
      bus.ocmd_index = 6'd0;
      bus.ocmd_arg   = 32'd0;
      unique case (state_q)
         S_C55:  bus.ocmd_index = 6'd55;
         S_C55B: begin
            bus.ocmd_index = 6'd55;
            bus.ocmd_arg   = rca_arg;
         end
         S_A41: begin
            bus.ocmd_index = 6'd41;
            bus.ocmd_arg   = 32'h8030_0000;
         end
         S_C2:   bus.ocmd_index = 6'd2;
         S_C3:   bus.ocmd_index = 6'd3;
         S_C7: begin
            bus.ocmd_index = 6'd7;
            bus.ocmd_arg   = rca_arg;
         end
         S_A6: begin
            bus.ocmd_index = 6'd6;
            bus.ocmd_arg   = 32'h2;
         end
         S_C17: begin
            bus.ocmd_index = 6'd17;
            bus.ocmd_arg   = blk_arg;
         end
         S_C24: begin
            bus.ocmd_index = 6'd24;
            bus.ocmd_arg   = blk_arg;
         end
         S_C15: begin
            bus.ocmd_index = 6'd15;
            bus.ocmd_arg   = rca_arg;
         end
         default: ;
      endcase
      bus.ostart_cmd = cmd_q;
      bus.ostart_d   = dst_q;
      bus.odata_wr   = (state_q == S_WRITE);
      osel_clk       = sel_q;
      owide          = wide_q;
      oaddr_sd       = addr_q;
      oblock_ready   = (state_q == S_HOLD);
      obusy          = (state_q != S_IDLE);
      osuccess       = succ_q;
      ofail          = fail_q;
      ofail_code     = code_q;
   end

endmodule

// File: tb/tb_sd_seq.sv
// tb_sd_seq: directed bench for sd_seq with a small scripted transceiver.
// DUT uses NUM_BLOCKS=2, ACMD41_TRIES=3, CRC_RETRIES=3, TIMEOUT_CYCLES=100.
module tb_sd_seq;
   logic       iclk = 1'b0;
   logic       irst = 1'b0;
   logic       istart = 1'b0;
   logic       iread = 1'b0;
   logic       iwrite = 1'b0;
   logic       osel_clk, owide, oblock_ready, obusy;
   logic       osuccess, ofail;
   logic [1:0] oaddr_sd;
   logic [2:0] ofail_code;
   int         checks = 0;
   int         errors = 0;

   sd_seq_if bus();

   sd_seq #(
      .BUS_WIDTH(4),
      .NUM_BLOCKS(2),
      .ADDR_W(2),
      .ACMD41_TRIES(3),
      .CRC_RETRIES(3),
      .TIMEOUT_CYCLES(100)
   ) u_dut (
      .iclk(iclk),
      .irst(irst),
      .istart(istart),
      .iread(iread),
      .iwrite(iwrite),
      .bus(bus),
      .osel_clk(osel_clk),
      .owide(owide),
      .oaddr_sd(oaddr_sd),
      .oblock_ready(oblock_ready),
      .obusy(obusy),
      .osuccess(osuccess),
      .ofail(ofail),
      .ofail_code(ofail_code)
   );

   always #5 iclk = ~iclk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cmd(input string tag, input logic [5:0] idx,
                      input logic [31:0] arg, input logic [31:0] resp);
      int n = 0;
      while (!bus.ostart_cmd && n < 300) begin
         @(negedge iclk);
         n++;
      end
      check({tag, "_seen"}, 32'(bus.ostart_cmd), 32'd1);
      check({tag, "_idx"}, 32'(bus.ocmd_index), 32'(idx));
      check({tag, "_arg"}, bus.ocmd_arg, arg);
      bus.iresp     = resp;
      bus.icmd_done = 1'b1;
      @(negedge iclk);
      bus.icmd_done = 1'b0;
      bus.iresp     = 32'd0;
   endtask

   task automatic dat(input string tag, input logic wr, input logic crc);
      int n = 0;
      while (!bus.ostart_d && n < 300) begin
         @(negedge iclk);
         n++;
      end
      check({tag, "_seen"}, 32'(bus.ostart_d), 32'd1);
      check({tag, "_wr"}, 32'(bus.odata_wr), 32'(wr));
      bus.idata_crc_fail = crc;
      bus.idata_done     = 1'b1;
      @(negedge iclk);
      bus.idata_done     = 1'b0;
      bus.idata_crc_fail = 1'b0;
   endtask

   task automatic pulse_start();
      istart = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
   endtask

   task automatic pulse_read();
      iread = 1'b1;
      @(negedge iclk);
      iread = 1'b0;
   endtask

   task automatic pulse_write();
      iwrite = 1'b1;
      @(negedge iclk);
      iwrite = 1'b0;
   endtask

   task automatic do_init();
      cmd("c55", 6'd55, 32'h0, 32'h20);
      cmd("a41", 6'd41, 32'h8030_0000, 32'h80FF_8000);
      cmd("c2", 6'd2, 32'h0, 32'h0);
      cmd("c3", 6'd3, 32'h0, 32'h1234_0000);
      cmd("c7", 6'd7, 32'h1234_0000, 32'h0);
      cmd("c55b", 6'd55, 32'h1234_0000, 32'h20);
      cmd("a6", 6'd6, 32'h2, 32'h800);
   endtask

   initial begin
      int n;
      bus.icmd_done      = 1'b0;
      bus.iresp          = 32'd0;
      bus.idata_done     = 1'b0;
      bus.idata_crc_fail = 1'b0;
      repeat (3) @(negedge iclk);
      check("rst_busy", 32'(obusy), 32'd0);
      check("rst_cmd", 32'(bus.ostart_cmd), 32'd0);
      check("rst_idx", 32'(bus.ocmd_index), 32'd0);
      check("rst_sel", 32'(osel_clk), 32'd0);
      check("rst_code", 32'(ofail_code), 32'd0);
      irst = 1'b1;
      @(negedge iclk);

      // Init with two ACMD41 busy polls, then a 4-bit switch.
      pulse_start();
      check("t1_busy", 32'(obusy), 32'd1);
      cmd("t1_c55_1", 6'd55, 32'h0, 32'h20);
      cmd("t1_a41_1", 6'd41, 32'h8030_0000, 32'h0);
      cmd("t1_c55_2", 6'd55, 32'h0, 32'h20);
      cmd("t1_a41_2", 6'd41, 32'h8030_0000, 32'h0);
      cmd("t1_c55_3", 6'd55, 32'h0, 32'h20);
      cmd("t1_a41_3", 6'd41, 32'h8030_0000, 32'h80FF_8000);
      cmd("t1_c2", 6'd2, 32'h0, 32'h0);
      cmd("t1_c3", 6'd3, 32'h0, 32'h1234_0000);
      check("t1_sel_pre", 32'(osel_clk), 32'd0);
      cmd("t1_c7", 6'd7, 32'h1234_0000, 32'h0);
      check("t1_sel", 32'(osel_clk), 32'd1);
      cmd("t1_c55b", 6'd55, 32'h1234_0000, 32'h20);
      check("t1_wide_pre", 32'(owide), 32'd0);
      cmd("t1_a6", 6'd6, 32'h2, 32'h800);
      check("t1_wide", 32'(owide), 32'd1);
      check("t1_wait_busy", 32'(obusy), 32'd1);
      check("t1_wait_rdy", 32'(oblock_ready), 32'd0);

      // Block 0 with three CRC retries, then block 1, then CMD15.
      pulse_read();
      cmd("t3_c17_0", 6'd17, 32'h0, 32'h0);
      dat("t4_rd_0", 1'b0, 1'b1);
      cmd("t4_c17_1", 6'd17, 32'h0, 32'h0);
      dat("t4_rd_1", 1'b0, 1'b1);
      cmd("t4_c17_2", 6'd17, 32'h0, 32'h0);
      dat("t4_rd_2", 1'b0, 1'b1);
      cmd("t4_c17_3", 6'd17, 32'h0, 32'h0);
      dat("t4_rd_3", 1'b0, 1'b0);
      check("t4_hold", 32'(oblock_ready), 32'd1);
      pulse_write();
      cmd("t3_c24_0", 6'd24, 32'h0, 32'h0);
      dat("t3_wr_0", 1'b1, 1'b0);
      check("t3_addr1", 32'(oaddr_sd), 32'd1);
      check("t3_rdy_off", 32'(oblock_ready), 32'd0);
      pulse_read();
      cmd("t3_c17_b1", 6'd17, 32'h200, 32'h0);
      dat("t3_rd_b1", 1'b0, 1'b0);
      check("t3_hold_b1", 32'(oblock_ready), 32'd1);
      pulse_write();
      cmd("t3_c24_b1", 6'd24, 32'h200, 32'h0);
      dat("t3_wr_b1", 1'b1, 1'b0);
      check("t3_succ_pre", 32'(osuccess), 32'd0);
      cmd("t3_c15", 6'd15, 32'h1234_0000, 32'h0);
      check("t3_succ", 32'(osuccess), 32'd1);
      check("t3_idle", 32'(obusy), 32'd0);
      @(negedge iclk);
      check("t3_succ_once", 32'(osuccess), 32'd0);

      // ACMD41 never ready: third poll exhausts the tries.
      pulse_start();
      check("t2_addr0", 32'(oaddr_sd), 32'd0);
      cmd("t2_c55_1", 6'd55, 32'h0, 32'h20);
      cmd("t2_a41_1", 6'd41, 32'h8030_0000, 32'h0);
      cmd("t2_c55_2", 6'd55, 32'h0, 32'h20);
      cmd("t2_a41_2", 6'd41, 32'h8030_0000, 32'h0);
      check("t2_nofail", 32'(ofail), 32'd0);
      cmd("t2_c55_3", 6'd55, 32'h0, 32'h20);
      cmd("t2_a41_3", 6'd41, 32'h8030_0000, 32'h0);
      check("t2_fail", 32'(ofail), 32'd1);
      check("t2_code", 32'(ofail_code), 32'd2);
      check("t2_idle", 32'(obusy), 32'd0);
      @(negedge iclk);
      check("t2_fail_once", 32'(ofail), 32'd0);
      check("t2_code_hold", 32'(ofail_code), 32'd2);

      // Four consecutive CRC failures.
      pulse_start();
      check("t4b_code_clr", 32'(ofail_code), 32'd0);
      do_init();
      pulse_read();
      for (int i = 0; i < 4; i++) begin
         cmd("t4b_c17", 6'd17, 32'h0, 32'h0);
         dat("t4b_rd", 1'b0, 1'b1);
      end
      check("t4b_fail", 32'(ofail), 32'd1);
      check("t4b_code", 32'(ofail_code), 32'd4);
      check("t4b_wide", 32'(owide), 32'd0);

      // Watchdog: CMD2 never answered.
      pulse_start();
      cmd("t5_c55", 6'd55, 32'h0, 32'h20);
      cmd("t5_a41", 6'd41, 32'h8030_0000, 32'h8000_0000);
      n = 0;
      while (!bus.ostart_cmd && n < 300) begin
         @(negedge iclk);
         n++;
      end
      check("t5_c2_idx", 32'(bus.ocmd_index), 32'd2);
      repeat (99) @(negedge iclk);
      check("t5_not_yet", 32'(ofail), 32'd0);
      check("t5_still_busy", 32'(obusy), 32'd1);
      @(negedge iclk);
      check("t5_fail", 32'(ofail), 32'd1);
      check("t5_code", 32'(ofail_code), 32'd5);
      check("t5_sel", 32'(osel_clk), 32'd0);

      // Asynchronous reset in WRITE.
      pulse_start();
      do_init();
      pulse_read();
      cmd("t6_c17", 6'd17, 32'h0, 32'h0);
      dat("t6_rd", 1'b0, 1'b0);
      pulse_write();
      cmd("t6_c24", 6'd24, 32'h0, 32'h0);
      n = 0;
      while (!bus.ostart_d && n < 300) begin
         @(negedge iclk);
         n++;
      end
      check("t6_in_wr", 32'(bus.odata_wr), 32'd1);
      check("t6_sel_pre", 32'(osel_clk), 32'd1);
      irst = 1'b0;
      #1;
      check("t6_busy", 32'(obusy), 32'd0);
      check("t6_sel", 32'(osel_clk), 32'd0);
      check("t6_wide", 32'(owide), 32'd0);
      check("t6_dstart", 32'(bus.ostart_d), 32'd0);
      check("t6_dwr", 32'(bus.odata_wr), 32'd0);
      check("t6_idx", 32'(bus.ocmd_index), 32'd0);
      repeat (2) @(negedge iclk);
      irst = 1'b1;
      @(negedge iclk);
      check("t6_quiet", 32'(ofail | osuccess), 32'd0);
      pulse_start();
      cmd("t6_restart", 6'd55, 32'h0, 32'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
